// File: rtl/game_pkg.sv
// Shared types and default widths for the counter-game stage and its result logger.
// Pure declarations; no logic, no latency, no flow control.
package game_pkg;

    localparam int CNT_W = 4;
    localparam int TOT_W = 8;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_t;

    typedef struct packed {
        logic [TOT_W-1:0] game_id;
        who_t             who;
        logic [CNT_W-1:0] wins;
        logic [CNT_W-1:0] losses;
    } result_rec_t;

    function automatic logic who_is_valid(input logic [1:0] w);
        return (w == 2'b01) || (w == 2'b10);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through record FIFO with async reset and synchronous clear.
// Latency: a record written at edge N is on pop_dat from edge N onward.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle; payload holds while pop_rdy is low.
module result_fifo #(
    parameter int  DEPTH = 4,
    parameter type rec_t = game_pkg::result_rec_t
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic push_vld,
    output logic push_rdy,
    input  rec_t push_dat,
    output logic pop_vld,
    input  logic pop_rdy,
    output rec_t pop_dat
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rec_t        mem [DEPTH];
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_rdy && !empty;
    assign push_rdy = !full || do_pop;
    assign do_push  = push_vld && push_rdy;
    assign pop_vld  = !empty;

    always_comb begin
        pop_dat = '0;
        if (!empty) begin
            pop_dat = mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/game_result_logger.sv
// Tallies counter-game pulses per game and logs one result record per finished game.
// Latency: record from a gameover at edge N is presented on ev_* from edge N onward.
// Backpressure: ev_valid/ev_ready handshake; a record arriving at a full, non-draining FIFO is dropped and flagged.
module game_result_logger #(
    parameter int CNT_W      = 4,
    parameter int TOT_W      = 8,
    parameter int HIST_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             winner,
    input  logic             loser,
    input  logic             gameover,
    input  logic [1:0]       who,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TOT_W-1:0] ev_game_id,
    output logic [1:0]       ev_who,
    output logic [CNT_W-1:0] ev_wins,
    output logic [CNT_W-1:0] ev_losses,
    output logic [TOT_W-1:0] games_won,
    output logic [TOT_W-1:0] games_lost,
    output logic             dropped,
    output logic             proto_err
);

    import game_pkg::*;

    typedef struct packed {
        logic [TOT_W-1:0] game_id;
        who_t             who;
        logic [CNT_W-1:0] wins;
        logic [CNT_W-1:0] losses;
    } rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] win_tally;
    logic [CNT_W-1:0] los_tally;
    logic [CNT_W-1:0] win_nxt;
    logic [CNT_W-1:0] los_nxt;
    logic [TOT_W-1:0] game_id;
    logic             end_game;
    logic             bad_game;
    logic             push_rdy;
    rec_t             push_rec;
    rec_t             head_rec;

    // The closing pulse can coincide with gameover, so the snapshot includes it.
    assign win_nxt  = (winner && win_tally != CNT_MAX) ? win_tally + CNT_W'(1) : win_tally;
    assign los_nxt  = (loser  && los_tally != CNT_MAX) ? los_tally + CNT_W'(1) : los_tally;
    assign end_game = gameover && who_is_valid(who);
    assign bad_game = gameover && !who_is_valid(who);

    always_comb begin
        push_rec         = '0;
        push_rec.game_id = game_id;
        push_rec.who     = (who == 2'b10) ? WHO_WINNER : WHO_LOSER;
        push_rec.wins    = win_nxt;
        push_rec.losses  = los_nxt;
    end

    result_fifo #(
        .DEPTH (HIST_DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .push_vld (end_game),
        .push_rdy (push_rdy),
        .push_dat (push_rec),
        .pop_vld  (ev_valid),
        .pop_rdy  (ev_ready),
        .pop_dat  (head_rec)
    );

    assign ev_game_id = head_rec.game_id;
    assign ev_who     = head_rec.who;
    assign ev_wins    = head_rec.wins;
    assign ev_losses  = head_rec.losses;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_tally  <= '0;
            los_tally  <= '0;
            game_id    <= '0;
            games_won  <= '0;
            games_lost <= '0;
            dropped    <= 1'b0;
            proto_err  <= 1'b0;
        end else if (clear) begin
            win_tally  <= '0;
            los_tally  <= '0;
            game_id    <= '0;
            games_won  <= '0;
            games_lost <= '0;
            dropped    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (end_game) begin
                win_tally <= '0;
                los_tally <= '0;
                // game_id advances even on a drop so the gap shows downstream.
                game_id   <= game_id + TOT_W'(1);
                if (who == 2'b10) begin
                    if (games_won != TOT_MAX) games_won <= games_won + TOT_W'(1);
                end else begin
                    if (games_lost != TOT_MAX) games_lost <= games_lost + TOT_W'(1);
                end
                if (!push_rdy) dropped <= 1'b1;
            end else begin
                win_tally <= win_nxt;
                los_tally <= los_nxt;
            end
            if (bad_game) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_game_result_logger.sv
// Directed vector bench for game_result_logger: table-driven game sequences plus
// hand-written reset/clear sequences with records queued.
module tb_game_result_logger;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       winner = 1'b0;
    logic       loser = 1'b0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'b00;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_game_id;
    logic [1:0] ev_who;
    logic [3:0] ev_wins;
    logic [3:0] ev_losses;
    logic [7:0] games_won;
    logic [7:0] games_lost;
    logic       dropped;
    logic       proto_err;

    always #5 clock = ~clock;

    game_result_logger #(
        .CNT_W      (4),
        .TOT_W      (8),
        .HIST_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .winner     (winner),
        .loser      (loser),
        .gameover   (gameover),
        .who        (who),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_game_id (ev_game_id),
        .ev_who     (ev_who),
        .ev_wins    (ev_wins),
        .ev_losses  (ev_losses),
        .games_won  (games_won),
        .games_lost (games_lost),
        .dropped    (dropped),
        .proto_err  (proto_err)
    );

    typedef struct {
        int         rep;
        logic       clr;
        logic       win;
        logic       los;
        logic       go;
        logic [1:0] wh;
        logic       rdy;
        logic       e_vld;
        int         e_id;
        int         e_who;
        int         e_w;
        int         e_l;
        int         e_won;
        int         e_lost;
        logic       e_drop;
        logic       e_perr;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(input int rep, input logic clr, input logic win, input logic los,
                                input logic go, input logic [1:0] wh, input logic rdy,
                                input logic e_vld, input int e_id, input int e_who, input int e_w,
                                input int e_l, input int e_won, input int e_lost,
                                input logic e_drop, input logic e_perr);
        vec_t v;
        v.rep = rep; v.clr = clr; v.win = win; v.los = los; v.go = go; v.wh = wh; v.rdy = rdy;
        v.e_vld = e_vld; v.e_id = e_id; v.e_who = e_who; v.e_w = e_w; v.e_l = e_l;
        v.e_won = e_won; v.e_lost = e_lost; v.e_drop = e_drop; v.e_perr = e_perr;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic e_vld, input int e_id, input int e_who,
                              input int e_w, input int e_l, input int e_won, input int e_lost,
                              input logic e_drop, input logic e_perr);
        check({tag, "_valid"},  int'(ev_valid),   int'(e_vld));
        check({tag, "_id"},     int'(ev_game_id), e_id);
        check({tag, "_who"},    int'(ev_who),     e_who);
        check({tag, "_wins"},   int'(ev_wins),    e_w);
        check({tag, "_losses"}, int'(ev_losses),  e_l);
        check({tag, "_won"},    int'(games_won),  e_won);
        check({tag, "_lost"},   int'(games_lost), e_lost);
        check({tag, "_drop"},   int'(dropped),    int'(e_drop));
        check({tag, "_perr"},   int'(proto_err),  int'(e_perr));
    endtask

    task automatic drive(input logic c, input logic w, input logic l, input logic g,
                         input logic [1:0] wh, input logic r);
        clear = c; winner = w; loser = l; gameover = g; who = wh; ev_ready = r;
    endtask

    // Queue two loser records and a protocol error, holding the consumer off.
    task automatic build_two_records();
        @(negedge clock); drive(0, 0, 0, 1, 2'b01, 0);
        @(negedge clock); drive(0, 0, 0, 1, 2'b01, 0);
        @(negedge clock); drive(0, 0, 0, 1, 2'b11, 0);
        @(negedge clock); drive(0, 0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        //                rep clr win los go who    rdy  vld id who w  l  won lost drop perr
        // first game: 3 losers, then loser + gameover
        vecs.push_back(mk(3,  0, 0, 1, 0, 2'b00, 1,  0,  0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 1, 1, 2'b01, 1,  1,  0, 1,  0, 4,  0, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  0, 1, 0, 0));
        // 14 winners, then the 15th together with gameover
        vecs.push_back(mk(14, 0, 1, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  0, 1, 0, 0));
        vecs.push_back(mk(1,  0, 1, 0, 1, 2'b10, 1,  1,  1, 2, 15, 0,  1, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  1, 1, 0, 0));
        // closing pulse not carried into the next game
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 1,  1,  2, 2,  0, 0,  2, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  2, 1, 0, 0));
        // tally saturation at 15
        vecs.push_back(mk(20, 0, 0, 1, 0, 2'b00, 1,  0,  0, 0,  0, 0,  2, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 1, 1, 2'b01, 1,  1,  3, 1,  0, 15, 2, 2, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  2, 2, 0, 0));
        // simultaneous winner and loser pulses
        vecs.push_back(mk(2,  0, 1, 1, 0, 2'b00, 1,  0,  0, 0,  0, 0,  2, 2, 0, 0));
        vecs.push_back(mk(1,  0, 1, 1, 1, 2'b10, 1,  1,  4, 2,  3, 3,  3, 2, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  3, 2, 0, 0));
        // invalid who: no record, tallies kept, that cycle's pulse counts
        vecs.push_back(mk(2,  0, 0, 1, 0, 2'b00, 1,  0,  0, 0,  0, 0,  3, 2, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b00, 1,  0,  0, 0,  0, 0,  3, 2, 0, 1));
        vecs.push_back(mk(1,  0, 0, 1, 1, 2'b01, 1,  1,  5, 1,  0, 3,  3, 3, 0, 1));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  3, 3, 0, 1));
        vecs.push_back(mk(1,  0, 0, 1, 1, 2'b11, 1,  0,  0, 0,  0, 0,  3, 3, 0, 1));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 1,  1,  6, 1,  0, 1,  3, 4, 0, 1));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  3, 4, 0, 1));
        // clear, then overflow with consumer stalled
        vecs.push_back(mk(1,  1, 0, 0, 0, 2'b00, 0,  0,  0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 0,  1,  0, 1,  0, 0,  0, 1, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 0,  1,  0, 1,  0, 0,  0, 2, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 0,  1,  0, 1,  0, 0,  0, 3, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 0,  1,  0, 1,  0, 0,  0, 4, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b01, 0,  1,  0, 1,  0, 0,  0, 5, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  1, 1,  0, 0,  0, 5, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  2, 1,  0, 0,  0, 5, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  3, 1,  0, 0,  0, 5, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  0, 5, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 1,  1,  5, 2,  0, 0,  1, 5, 1, 0));
        // clear, fill, then push and pop together while full
        vecs.push_back(mk(1,  1, 0, 0, 0, 2'b00, 0,  0,  0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 0,  1,  0, 2,  0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 0,  1,  0, 2,  0, 0,  2, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 0,  1,  0, 2,  0, 0,  3, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 0,  1,  0, 2,  0, 0,  4, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 1, 2'b10, 1,  1,  1, 2,  0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  2, 2,  0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  3, 2,  0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  1,  4, 2,  0, 0,  5, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 2'b00, 1,  0,  0, 0,  0, 0,  5, 0, 0, 0));

        #12;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].clr, vecs[i].win, vecs[i].los, vecs[i].go, vecs[i].wh, vecs[i].rdy);
            repeat (vecs[i].rep) @(posedge clock);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_id, vecs[i].e_who,
                       vecs[i].e_w, vecs[i].e_l, vecs[i].e_won, vecs[i].e_lost,
                       vecs[i].e_drop, vecs[i].e_perr);
        end

        // Asynchronous reset mid-cycle with two records waiting.
        build_two_records();
        #1;
        check_outs("pre_rst", 1, 5, 1, 0, 0, 5, 2, 0, 1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Same sequence, cleared synchronously instead.
        build_two_records();
        #1;
        check_outs("pre_clr", 1, 0, 1, 0, 0, 0, 2, 0, 1);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check("clr_before_edge", int'(ev_valid), 1);
        @(posedge clock);
        #1;
        check_outs("sync_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 1, 2'b10, 1);
        @(posedge clock);
        #1;
        check_outs("after_clr", 1, 0, 2, 0, 0, 1, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_result_logger.md
Name: game_result_logger

Overview:
- Downstream consumer of the counter-game stage.
- Samples that stage's one-cycle WINNER/LOSER pulses and its GAMEOVER/WHO outcome, and tallies per-game hit counts and lifetime win/loss totals.
- Pushes one result record per finished game into a small FIFO.
- Presents each record to a host/display stage over a valid/ready handshake.

Parameters:
- CNT_W, 4, width of per-game pulse tallies; matches the counter stage's 4-bit winner/loser counters.
- TOT_W, 8, width of lifetime game totals and game_id.
- HIST_DEPTH, 4, FIFO depth in records; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock, shared with the counter stage.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; same effect as reset, takes effect at the next edge.
- winner  in  1  one-cycle pulse: counter reached all-ones.
- loser  in  1  one-cycle pulse: counter reached zero.
- gameover  in  1  one-cycle pulse: a game has finished.
- who  in  2  outcome, qualified by gameover: 01 = loser, 10 = winner.
- ev_valid  out  1  a record is available.
- ev_ready  in  1  consumer accepts the record.
- ev_game_id  out  TOT_W  sequence number of the record.
- ev_who  out  2  outcome of that game.
- ev_wins  out  CNT_W  winner pulses counted in that game.
- ev_losses  out  CNT_W  loser pulses counted in that game.
- games_won  out  TOT_W  lifetime count of winner outcomes.
- games_lost  out  TOT_W  lifetime count of loser outcomes.
- dropped  out  1  sticky: a record was lost because the FIFO was full.
- proto_err  out  1  sticky: gameover arrived with who = 00 or 11.

Behaviour:
- Reset (reset_n = 0, asynchronous) and clear both zero the following. ev_valid and all outputs read 0.
  - all tallies, totals, game_id, FIFO pointers and sticky flags
- Tallies: win_tally / los_tally increment on winner / loser.
  - Each saturates at 2^CNT_W-1.
  - If winner and loser arrive in the same cycle, both increment.
- Gameover cycle with valid who (01 or 10):
  - Snapshot = tally + that cycle's pulse. The counter stage asserts the 15th pulse and gameover in the same cycle, so that pulse must be included.
  - Record {game_id, who, snap_wins, snap_losses} is pushed.
  - Tallies reset to 0. A pulse in this same cycle is not carried into the next game.
  - game_id += 1, wrapping modulo 2^TOT_W.
  - games_won (who = 10) or games_lost (who = 01) += 1, saturating at 2^TOT_W-1.
- Gameover with invalid who (00 or 11):
  - Set proto_err; no push.
  - Tallies, totals and game_id are unchanged; that cycle's pulses still count.
- Latency: a record pushed at edge N drives ev_valid high from edge N onward, i.e. visible in the cycle after the gameover cycle.
- FIFO, first-word-fall-through:
  - ev_valid = not empty.
  - A pop occurs when ev_valid and ev_ready are both high at an edge.
  - While ev_valid = 1 and ev_ready = 0, the payload holds stable.
- Full FIFO:
  - Push with no pop in the same cycle: record dropped, dropped set. game_id and totals still advance, so the gap is visible in ev_game_id.
  - Push and pop in the same cycle: both succeed; occupancy unchanged.
- Empty FIFO: ev_ready is ignored and no pop occurs.
- Reset asserted mid-handshake: the record is lost; ev_valid goes to 0 immediately.
- No state machine beyond the FIFO pointers. All updates happen on the rising clock edge.

Decomposition:
- game_pkg holds:
  - who_t enum: WHO_NONE = 2'b00, WHO_LOSER = 2'b01, WHO_WINNER = 2'b10.
  - result_rec_t packed struct {game_id, who, wins, losses}.
  - Default width constants CNT_W = 4 and TOT_W = 8; the counter stage also imports these.
- Sub-module result_fifo: parameterised on depth and on result_rec_t.
  - Handles push, pop, full, empty and FWFT output.
  - Async active-low reset plus synchronous clear.
- The top level holds the tallies, the totals and the error flags.

Test Plan:
- Reset, then 3 loser pulses, then a loser + gameover pulse with who = 01, ev_ready = 1 → next cycle: ev_valid = 1, record {0, 01, 0, 4}, games_lost = 1; ev_valid = 0 after the pop.
- winner + gameover pulse in the same cycle with who = 10, after 14 prior winner pulses → record wins = 15, losses = 0, games_won = 1; the next game's tallies start at 0.
- ev_ready = 0, 5 games finished (HIST_DEPTH = 4) → four records with game_id 0..3 held stable; dropped = 1.
  - Then ev_ready = 1: game_ids 0, 1, 2, 3 drain in order, then ev_valid = 0.
  - A following game yields game_id 5.
- FIFO full with ev_ready = 1 and a gameover in the same cycle → no drop, dropped stays 0, occupancy stays 4.
- gameover with who = 00 after 2 loser pulses → proto_err = 1, no record, los_tally stays 2. A later valid gameover with who = 01 and a loser pulse reports losses = 3.
- reset_n driven low asynchronously mid-cycle with 2 records queued → ev_valid, totals and flags read 0 before the next clock edge. Repeat the sequence using clear instead and check identical results at the next edge.
